// File: rtl/video_mode_ctrl_if.sv
// Hot-key, button and vsync inputs plus mode/reset outputs of video_mode_ctrl.
// slave = the controller side, master = the source/consumer side.
interface video_mode_ctrl_if;
   logic       scan_toggle_i;
   logic       sd_toggle_i;
   logic       rst_req_i;
   logic       btn_scan_n_i;
   logic       vsync_i;
   logic [1:0] scanlines_o;
   logic       scandoubler_disable_o;
   logic       core_reset_o;
   logic       video_blank_o;
   logic       busy_o;

   modport slave (
      input  scan_toggle_i, sd_toggle_i, rst_req_i, btn_scan_n_i, vsync_i,
      output scanlines_o, scandoubler_disable_o, core_reset_o, video_blank_o, busy_o
   );

   modport master (
      output scan_toggle_i, sd_toggle_i, rst_req_i, btn_scan_n_i, vsync_i,
      input  scanlines_o, scandoubler_disable_o, core_reset_o, video_blank_o, busy_o
   );
endinterface

// File: rtl/video_mode_ctrl.sv
// Video mode / core reset sequencer: scanline level, scandoubler bypass with frame blanking,
// fixed-length core reset. Define MODE_VSYNC_ALIGN_EN to align the scandoubler toggle to vsync.
module video_mode_ctrl #(
   parameter int RESET_CYCLES  = 1024,
   parameter int BLANK_FRAMES  = 4,
   parameter int DEBOUNCE_BITS = 10
) (
   input  logic             clk_sys,
   input  logic             reset,
   video_mode_ctrl_if.slave bus
);

   localparam int RST_W = $clog2(RESET_CYCLES + 1);
   localparam int FRM_W = $clog2(BLANK_FRAMES + 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLANK_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BLANK = 2'd2
`ifdef MODE_VSYNC_ALIGN_EN
      , ST_PEND = 2'd3
`endif
   } state_t;

   logic scan_lvl_q, scan_lvl_d, sd_lvl_q, sd_lvl_d;
   logic rreq_lvl_q, rreq_lvl_d, vs_lvl_q, vs_lvl_d;
   logic btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
   logic btn_db_q, btn_db_d, btn_db_prev_q, btn_db_prev_d;
   logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;

   state_t           state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
   logic [1:0]       scanlines_q, scanlines_d;
   logic             sd_dis_q, sd_dis_d;
   logic             core_reset_q, core_reset_d;
   logic             blank_q, blank_d;
   logic             busy_q, busy_d;

   logic scan_ev, sd_ev, rst_ev, vs_ev, btn_ev;

   always_comb begin
      scan_ev = bus.scan_toggle_i & ~scan_lvl_q;
      sd_ev   = bus.sd_toggle_i   & ~sd_lvl_q;
      rst_ev  = bus.rst_req_i     & ~rreq_lvl_q;
      vs_ev   = bus.vsync_i       & ~vs_lvl_q;
      btn_ev  = btn_db_prev_q     & ~btn_db_q;

      scan_lvl_d = bus.scan_toggle_i;
      sd_lvl_d   = bus.sd_toggle_i;
      rreq_lvl_d = bus.rst_req_i;
      vs_lvl_d   = bus.vsync_i;
   end

   // The debounced level only moves after the synchronised input has disagreed with it
   // for 2^DEBOUNCE_BITS consecutive cycles; any agreeing sample restarts the count.
   always_comb begin
      btn_meta_d    = bus.btn_scan_n_i;
      btn_sync_d    = btn_meta_q;
      btn_db_prev_d = btn_db_q;
      btn_db_d      = btn_db_q;
      db_cnt_d      = '0;
      if (btn_sync_q != btn_db_q) begin
         if (db_cnt_q == '1) btn_db_d = btn_sync_q;
         else                db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   always_comb begin
      // NOTE: every signal gets its default first so no path can leave it unassigned (no latch).
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      frm_cnt_d   = frm_cnt_q;
      scanlines_d = scanlines_q;
      sd_dis_d    = sd_dis_q;

      if ((scan_ev | btn_ev) && state_q != ST_RST) scanlines_d = scanlines_q + 2'd1;

      if (rst_ev) begin
         state_d   = ST_RST;
         rst_cnt_d = '0;
      end else begin
         case (state_q)
            ST_RST: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_d   = ST_IDLE;
                  rst_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (sd_ev) begin
`ifdef MODE_VSYNC_ALIGN_EN
                  state_d   = ST_PEND;
`else
                  sd_dis_d  = ~sd_dis_q;
                  state_d   = ST_BLANK;
                  frm_cnt_d = '0;
`endif
               end
            end
`ifdef MODE_VSYNC_ALIGN_EN
            ST_PEND: begin
               if (vs_ev) begin
                  sd_dis_d  = ~sd_dis_q;
                  state_d   = ST_BLANK;
                  frm_cnt_d = '0;
               end
            end
`endif
            ST_BLANK: begin
               if (vs_ev) begin
                  if (frm_cnt_q == FRM_LAST) begin
                     state_d   = ST_IDLE;
                     frm_cnt_d = '0;
                  end else begin
                     frm_cnt_d = frm_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d   = ST_RST;
               rst_cnt_d = '0;
            end
         endcase
      end

      // Status outputs are registered copies of the next state, so they move with it.
      core_reset_d = (state_d == ST_RST);
      blank_d      = (state_d == ST_BLANK);
      busy_d       = (state_d != ST_IDLE);
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         scan_lvl_q    <= 1'b0;
         sd_lvl_q      <= 1'b0;
         rreq_lvl_q    <= 1'b0;
         vs_lvl_q      <= 1'b0;
         btn_meta_q    <= 1'b1;
         btn_sync_q    <= 1'b1;
         btn_db_q      <= 1'b1;
         btn_db_prev_q <= 1'b1;
         db_cnt_q      <= '0;
         state_q       <= ST_RST;
         rst_cnt_q     <= '0;
         frm_cnt_q     <= '0;
         scanlines_q   <= 2'd0;
         sd_dis_q      <= 1'b0;
         core_reset_q  <= 1'b1;
         blank_q       <= 1'b0;
         busy_q        <= 1'b1;
      end else begin
         scan_lvl_q    <= scan_lvl_d;
         sd_lvl_q      <= sd_lvl_d;
         rreq_lvl_q    <= rreq_lvl_d;
         vs_lvl_q      <= vs_lvl_d;
         btn_meta_q    <= btn_meta_d;
         btn_sync_q    <= btn_sync_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_prev_d;
         db_cnt_q      <= db_cnt_d;
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         frm_cnt_q     <= frm_cnt_d;
         scanlines_q   <= scanlines_d;
         sd_dis_q      <= sd_dis_d;
         core_reset_q  <= core_reset_d;
         blank_q       <= blank_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.scanlines_o           = scanlines_q;
   assign bus.scandoubler_disable_o = sd_dis_q;
   assign bus.core_reset_o          = core_reset_q;
   assign bus.video_blank_o         = blank_q;
   assign bus.busy_o                = busy_q;

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Sequencer for the arcade top's user-facing video and reset controls. It turns keyboard hot-key levels, the raw scanline button and the game vsync into stable mode registers: scanline level and scandoubler bypass. It sequences a clean mode switch by blanking video for whole frames around a scandoubler toggle, and it issues a fixed-length core reset. It sits between `kbd_joystick`/button inputs and the `mist_video` and `scramble_top` configuration inputs, and replaces ad-hoc edge-clocked toggles with single-clock logic.

## Interface
Parameters:
- `RESET_CYCLES`, 1024: length of core reset pulse in `clk_sys` cycles (>=1).
- `BLANK_FRAMES`, 4: vsync rising edges of forced blanking after a scandoubler toggle (>=1).
- `DEBOUNCE_BITS`, 10: button must be stable for 2^DEBOUNCE_BITS cycles to be accepted.

Ports:
- `clk_sys`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `scan_toggle_i`  in  1: keyboard scanline hot-key level; a rising edge is one event.
- `sd_toggle_i`  in  1: keyboard scandoubler hot-key level; a rising edge is one event.
- `rst_req_i`  in  1: keyboard reset hot-key level; a rising edge is one event.
- `btn_scan_n_i`  in  1: raw asynchronous button, active low; a debounced press is one scanline event.
- `vsync_i`  in  1: game vsync, active high, synchronous to `clk_sys`.
- `scanlines_o`  out  2: scanline level for the video block.
- `scandoubler_disable_o`  out  1: 0 = 31 kHz VGA, 1 = 15 kHz.
- `core_reset_o`  out  1: active-high reset to the game core.
- `video_blank_o`  out  1: force RGB to zero.
- `busy_o`  out  1: high whenever the state is not IDLE.

## Operation
- Edge detect: each `*_i` level is registered once. event = level & ~registered. `vsync_i` is handled the same way and gives `vs_rise`.
- Button: 2-flop synchroniser, then a debounce counter that restarts on any change. The debounced value resets to 1 (released). A 1->0 transition of the debounced value is a scanline event.
- Scanline event (key or button) in any state except RST: `scanlines_o <= scanlines_o + 1`, 2-bit wrap, so 3 -> 0. A key event and a button event in the same cycle count as one increment.
- States: RST, IDLE, PEND (only with the macro), BLANK.
  - RST: `core_reset_o`=1 and the counter counts RESET_CYCLES. On the last count go to IDLE and drop `core_reset_o`. Scanline events here are dropped.
  - IDLE: reset event -> RST. Otherwise a scandoubler event toggles or pends as described under Configuration, then -> BLANK or PEND.
  - PEND: on `vs_rise`, toggle `scandoubler_disable_o` and go to BLANK.
  - BLANK: `video_blank_o`=1. The frame counter counts `vs_rise` edges. On the BLANK_FRAMES-th edge go to IDLE.
- Reset event in any state (including RST): go to RST and restart the counter. `core_reset_o`=1. `video_blank_o` clears. A pending toggle is discarded. `scanlines_o` and `scandoubler_disable_o` keep their values.
- Scandoubler events in PEND, BLANK or RST are dropped, not queued.
- Same-cycle priority: reset > scandoubler. A scanline event is still applied in that cycle unless the current state is RST.

## Timing
- Values after `reset`: state RST with counter 0. `core_reset_o`=1, `scanlines_o`=0, `scandoubler_disable_o`=0, `video_blank_o`=0, `busy_o`=1. Debounced button = 1. Edge registers = 0.
- Release: `core_reset_o` stays high for exactly RESET_CYCLES cycles after `reset` deasserts, then goes low together with `busy_o`.
- Event latency: when a level is first sampled high at edge k, the affected outputs change at edge k. Outputs are visible 1 cycle after the input rises.
- Button latency: 2 synchroniser cycles + 2^DEBOUNCE_BITS stable cycles + 1.
- Blank window: `video_blank_o` rises on the edge that toggles `scandoubler_disable_o`. It falls on the edge where the BLANK_FRAMES-th `vs_rise` is detected.
- A `vs_rise` in the same cycle as the toggle does not count as a frame.
- All outputs are registered.

## Configuration
- `MODE_VSYNC_ALIGN_EN` defined: a scandoubler event in IDLE enters PEND. The toggle and the start of blanking wait for the next `vs_rise`, so the mode switch is frame-aligned.
- Not defined: the PEND state is not built. A scandoubler event in IDLE toggles `scandoubler_disable_o` and enters BLANK on the same edge.

## Test plan
- Power-up: pulse `reset` for 1 cycle with RESET_CYCLES=16 -> `core_reset_o`=1 for exactly 16 cycles after release, all other outputs at their reset values, then `busy_o`=0.
- Scanline wrap: 5 `scan_toggle_i` pulses in IDLE -> `scanlines_o` goes 1,2,3,0,1, each 1 cycle after its edge.
- Button debounce with DEBOUNCE_BITS=4: a bouncing press (toggle every 3 cycles for 40 cycles), then held low -> exactly one increment, 2+16+1 cycles after the last bounce.
- Scandoubler with BLANK_FRAMES=2, run with and without the macro:
  - Macro on: the toggle lands on the first `vs_rise` after the event.
  - Macro off: the toggle is immediate.
  - Both: blanking lasts until the 2nd following `vs_rise`. A second `sd_toggle_i` during BLANK is ignored and `scandoubler_disable_o` ends at 1.
- Reset mid-blank: `rst_req_i` rises during BLANK while `scanlines_o`=2 -> `video_blank_o`=0 and `core_reset_o`=1 on the same edge, RESET_CYCLES cycles in RST, `scanlines_o` still 2.
- Simultaneous events: `rst_req_i`, `sd_toggle_i` and `scan_toggle_i` all rise in one IDLE cycle -> state RST, `scandoubler_disable_o` unchanged, `scanlines_o` incremented once.
